// File: rtl/mymem_pkg.sv
// Shared definitions for the scratch-memory command sequencer: default
// geometry, command opcodes and the sequencer state encoding.
package mymem_pkg;

  localparam int MYMEM_ADDR_W = 10;
  localparam int MYMEM_DATA_W = 64;
  localparam int MYMEM_LEN_W  = MYMEM_ADDR_W + 1;
  localparam int MYMEM_DEPTH  = 2 ** MYMEM_ADDR_W;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_SUM   = 2'd2,
    OP_FILL  = 2'd3
  } op_e;

  // RD_ISSUE is kept in the encoding for compatibility; single reads run
  // through ISSUE with an effective length of one.
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    ISSUE,
    DRAIN,
    FILL,
    RESP
  } state_e;

endpackage

// File: rtl/mymem_cmd_ctrl.sv
// Command sequencer in front of the on-chip scratch memory. Takes one
// command at a time from the accelerator core, drives the registered memory
// request port, folds read returns into an accumulator and hands back exactly
// one response per command.
module mymem_cmd_ctrl
  import mymem_pkg::*;
#(
  parameter int ADDR_W = MYMEM_ADDR_W,
  parameter int DATA_W = MYMEM_DATA_W,
  parameter int LEN_W  = MYMEM_LEN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic              mem_rqvalid,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic              mem_rdvalid,
  input  logic [DATA_W-1:0] mem_rddata
);

  // Largest word count a single command can touch: the whole memory once.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_e             state;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   issue_cnt;
  logic [LEN_W-1:0]   rcv_cnt;
  logic [DATA_W-1:0]  acc;

  logic [LEN_W-1:0]   len_clamp;
  logic [DATA_W-1:0]  acc_next;
  logic [LEN_W-1:0]   rcv_next;

  assign len_clamp = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign acc_next  = acc + mem_rddata;
  assign rcv_next  = rcv_cnt + LEN_W'(1);

  // Sequencer FSM: every output, memory port included, is registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      busy        <= 1'b0;
      mem_rqvalid <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_wrdata  <= '0;
      len_eff     <= '0;
      issue_cnt   <= '0;
      rcv_cnt     <= '0;
      acc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            acc        <= '0;
            rcv_cnt    <= '0;
            issue_cnt  <= LEN_W'(1);
            mem_addr   <= cmd_addr;
            mem_wrdata <= cmd_data;
            len_eff    <= len_clamp;
            case (op_e'(cmd_op))
              OP_WRITE: begin
                mem_wren <= 1'b1;
                state    <= WR;
              end
              OP_READ: begin
                len_eff     <= LEN_W'(1);
                mem_rqvalid <= 1'b1;
                state       <= ISSUE;
              end
              OP_SUM: begin
                if (len_clamp == '0) begin
                  resp_data  <= '0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
                end else begin
                  mem_rqvalid <= 1'b1;
                  state       <= ISSUE;
                end
              end
              default: begin
                if (len_clamp == '0) begin
                  resp_data  <= '0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
                end else begin
                  mem_wren <= 1'b1;
                  state    <= FILL;
                end
              end
            endcase
          end
        end

        WR: begin
          mem_wren   <= 1'b0;
          resp_data  <= DATA_W'(1);
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        ISSUE: begin
          if (mem_rdvalid) begin
            acc     <= acc_next;
            rcv_cnt <= rcv_next;
          end
          if (issue_cnt == len_eff) begin
            mem_rqvalid <= 1'b0;
            state       <= DRAIN;
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            issue_cnt <= issue_cnt + LEN_W'(1);
          end
        end

        DRAIN: begin
          if (mem_rdvalid) begin
            acc     <= acc_next;
            rcv_cnt <= rcv_next;
            if (rcv_next == len_eff) begin
              resp_data  <= acc_next;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end

        FILL: begin
          if (issue_cnt == len_eff) begin
            mem_wren   <= 1'b0;
            resp_data  <= DATA_W'(len_eff);
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            issue_cnt <= issue_cnt + LEN_W'(1);
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          mem_rqvalid <= 1'b0;
          mem_wren    <= 1'b0;
          resp_valid  <= 1'b0;
          cmd_ready   <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mymem_cmd_ctrl.sv
// Self-checking bench for the scratch-memory command sequencer, with a
// behavioural 1024x64 memory (one-cycle read latency) on the request port.
module tb_mymem_cmd_ctrl;
  import mymem_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [63:0] cmd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        busy;
  logic        mem_rqvalid;
  logic        mem_wren;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wrdata;
  logic        mem_rdvalid;
  logic [63:0] mem_rddata;

  int tests_run;
  int tests_failed;
  int wr_seen;
  int rq_seen;
  int both_seen;

  logic [63:0] mem [MYMEM_DEPTH];

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [9:0]  addr;
    logic [10:0] len;
    logic [63:0] data;
    logic [63:0] exp_resp;
    int          exp_lat;
    int          exp_wr;
    int          exp_rq;
    int          hold;
  } vec_t;

  localparam int NUM_VECS = 21;
  vec_t vecs [NUM_VECS];

  mymem_cmd_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .busy        (busy),
    .mem_rqvalid (mem_rqvalid),
    .mem_wren    (mem_wren),
    .mem_addr    (mem_addr),
    .mem_wrdata  (mem_wrdata),
    .mem_rdvalid (mem_rdvalid),
    .mem_rddata  (mem_rddata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scratch memory: reads return one cycle after the request, no reset.
  initial begin
    for (int i = 0; i < MYMEM_DEPTH; i++) mem[i] = '0;
    mem_rdvalid = 1'b0;
    mem_rddata  = '0;
  end

  always @(posedge clock) begin
    mem_rdvalid <= mem_rqvalid;
    if (mem_rqvalid) mem_rddata <= mem[mem_addr];
    if (mem_wren) mem[mem_addr] <= mem_wrdata;
  end

  // Running tallies of memory port activity, sampled at the active edge.
  initial begin
    wr_seen = 0;
    rq_seen = 0;
    both_seen = 0;
  end

  always @(posedge clock) begin
    if (mem_wren) wr_seen++;
    if (mem_rqvalid) rq_seen++;
    if (mem_wren && mem_rqvalid) both_seen++;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Issues one command, measures latency and port activity, optionally
  // stalls the response, then completes the response handshake.
  task automatic applyStimulus(input vec_t v);
    int          wr0;
    int          rq0;
    int          wr_mid;
    int          rq_mid;
    int          lat;
    logic [63:0] held;
    bit          hold_bad;

    @(negedge clock);
    cmd_op     = v.op;
    cmd_addr   = v.addr;
    cmd_len    = v.len;
    cmd_data   = v.data;
    cmd_valid  = 1'b1;
    resp_ready = 1'b0;
    checkOutput({v.name, " cmd_ready"}, 64'(cmd_ready), 64'(1));
    wr0 = wr_seen;
    rq0 = rq_seen;

    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = 10'($urandom);
    cmd_len   = 11'($urandom);
    cmd_data  = {$urandom, $urandom};

    lat = 1;
    while (!resp_valid && lat < 3000) begin
      @(negedge clock);
      lat++;
    end
    if (!resp_valid) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s timeout: got no resp_valid, expected within 3000 cycles", v.name);
    end
    checkOutput({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
    checkOutput({v.name, " resp_data"}, resp_data, v.exp_resp);

    if (v.hold > 0) begin
      held     = resp_data;
      hold_bad = 1'b0;
      wr_mid   = wr_seen;
      rq_mid   = rq_seen;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clock);
        if (!resp_valid || resp_data !== held || cmd_ready || !busy) hold_bad = 1'b1;
      end
      checkOutput({v.name, " hold stable"}, 64'(hold_bad), 64'(0));
      checkOutput({v.name, " hold mem idle"}, 64'((wr_seen - wr_mid) + (rq_seen - rq_mid)), 64'(0));
    end

    checkOutput({v.name, " wren cycles"}, 64'(wr_seen - wr0), 64'(v.exp_wr));
    checkOutput({v.name, " rqvalid cycles"}, 64'(rq_seen - rq0), 64'(v.exp_rq));

    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    checkOutput({v.name, " back to idle"}, 64'({resp_valid, cmd_ready, busy}), 64'(3'b010));
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " ctrl"}, 64'({cmd_ready, resp_valid, busy, mem_rqvalid, mem_wren}),
                64'(5'b10000));
    checkOutput({name, " mem_addr"}, 64'(mem_addr), 64'(0));
    checkOutput({name, " mem_wrdata"}, mem_wrdata, 64'(0));
    checkOutput({name, " resp_data"}, resp_data, 64'(0));
  endtask

  initial begin
    vec_t  v;
    bit    stray_resp;

    tests_run    = 0;
    tests_failed = 0;

    //            name            op        addr  len   data                    resp                    lat   wr    rq    hold
    vecs[0]  = '{"write5",       OP_WRITE, 10'd5,    11'd0,    64'hDEAD_BEEF, 64'd1,                 2,    1,    0,    0};
    vecs[1]  = '{"read5",        OP_READ,  10'd5,    11'd0,    64'd0,         64'hDEAD_BEEF,         3,    0,    1,    0};
    vecs[2]  = '{"fill_wrap",    OP_FILL,  10'd1020, 11'd8,    64'd7,         64'd8,                 9,    8,    0,    0};
    vecs[3]  = '{"sum_wrap",     OP_SUM,   10'd1020, 11'd8,    64'd0,         64'd56,                10,   0,    8,    0};
    vecs[4]  = '{"read1023",     OP_READ,  10'd1023, 11'd0,    64'd0,         64'd7,                 3,    0,    1,    0};
    vecs[5]  = '{"read3",        OP_READ,  10'd3,    11'd0,    64'd0,         64'd7,                 3,    0,    1,    0};
    vecs[6]  = '{"read4",        OP_READ,  10'd4,    11'd0,    64'd0,         64'd0,                 3,    0,    1,    0};
    vecs[7]  = '{"sum_len0",     OP_SUM,   10'd0,    11'd0,    64'd0,         64'd0,                 1,    0,    0,    0};
    vecs[8]  = '{"fill_len0",    OP_FILL,  10'd0,    11'd0,    64'd9,         64'd0,                 1,    0,    0,    0};
    vecs[9]  = '{"read0",        OP_READ,  10'd0,    11'd0,    64'd0,         64'd7,                 3,    0,    1,    0};
    vecs[10] = '{"write10_hold", OP_WRITE, 10'd10,   11'd0,    64'd3,         64'd1,                 2,    1,    0,    20};
    vecs[11] = '{"write11",      OP_WRITE, 10'd11,   11'd0,    64'd5,         64'd1,                 2,    1,    0,    0};
    vecs[12] = '{"sum10_2",      OP_SUM,   10'd10,   11'd2,    64'd0,         64'd8,                 4,    0,    2,    0};
    vecs[13] = '{"sum_len1",     OP_SUM,   10'd1022, 11'd1,    64'd0,         64'd7,                 3,    0,    1,    0};
    vecs[14] = '{"read_len_ign", OP_READ,  10'd11,   11'd500,  64'd0,         64'd5,                 3,    0,    1,    0};
    vecs[15] = '{"fill_all",     OP_FILL,  10'd0,    11'd2047, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1024,    1025, 1024, 0,    0};
    vecs[16] = '{"sum_clamp",    OP_SUM,   10'd0,    11'd2047, 64'd0,         64'hFFFF_FFFF_FFFF_FC00, 1026, 0,  1024, 0};
    vecs[17] = '{"sum_depth",    OP_SUM,   10'd512,  11'd1024, 64'd0,         64'hFFFF_FFFF_FFFF_FC00, 1026, 0,  1024, 0};
    vecs[18] = '{"fill_1",       OP_FILL,  10'd1023, 11'd1,    64'h11,        64'd1,                 2,    1,    0,    0};
    vecs[19] = '{"read1023_b",   OP_READ,  10'd1023, 11'd0,    64'd0,         64'h11,                3,    0,    1,    0};
    vecs[20] = '{"read0_b",      OP_READ,  10'd0,    11'd0,    64'd0,         64'hFFFF_FFFF_FFFF_FFFF, 3,  0,    1,    0};

    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_data   = '0;
    resp_ready = 1'b0;
    reset_n    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkResetValues("post reset");

    for (int i = 0; i < NUM_VECS; i++) applyStimulus(vecs[i]);

    checkOutput("no rq+wr overlap", 64'(both_seen), 64'(0));

    // Reset in the middle of a long SUM, released before the next edge so a
    // stale read return lands while the sequencer is idle.
    v = '{"write5_pre", OP_WRITE, 10'd5, 11'd0, 64'hA5A5_5A5A_0F0F_F0F0, 64'd1, 2, 1, 0, 0};
    applyStimulus(v);

    @(negedge clock);
    cmd_op    = OP_SUM;
    cmd_addr  = 10'd0;
    cmd_len   = 11'd100;
    cmd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (39) @(negedge clock);
    checkOutput("mid sum busy/rq", 64'({busy, mem_rqvalid, cmd_ready}), 64'(3'b110));
    reset_n = 1'b0;
    #1;
    checkResetValues("mid sum reset");
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkResetValues("after stale rdvalid");
    stray_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (resp_valid || busy || mem_rqvalid || mem_wren) stray_resp = 1'b1;
    end
    checkOutput("no response after reset", 64'(stray_resp), 64'(0));

    v = '{"read5_post", OP_READ, 10'd5, 11'd0, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 3, 0, 1, 0};
    applyStimulus(v);

    checkOutput("no rq+wr overlap final", 64'(both_seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mymem_cmd_ctrl.md
Name: mymem_cmd_ctrl

Overview:
- Command sequencer directly upstream of the 1024x64 on-chip scratch memory.
- Accepts valid/ready commands from the RoCC accelerator core: single write, single read, range sum, range fill.
- Drives the memory request port (rqvalid/wren/addr/wrdata), consumes its 1-cycle-latency read return (rdvalid/rddata), and returns exactly one response per command.

Parameters:
- ADDR_W, 10, memory address width; DEPTH = 2**ADDR_W.
- DATA_W, 64, data word width.
- LEN_W, 11, length field width (ADDR_W+1, so it can encode DEPTH).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  0=WRITE, 1=READ, 2=SUM, 3=FILL.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  word count for SUM/FILL; ignored for WRITE/READ.
- cmd_data  in  DATA_W  write/fill data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_data  out  DATA_W  response payload.
- busy  out  1  high whenever state != IDLE.
- mem_rqvalid  out  1  read request to memory.
- mem_wren  out  1  write enable to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wrdata  out  DATA_W  memory write data.
- mem_rdvalid  in  1  read data valid; asserts 1 cycle after mem_rqvalid.
- mem_rddata  in  DATA_W  read data.

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_ready=1; resp_valid=0; resp_data=0; busy=0; mem_rqvalid=0; mem_wren=0; mem_addr=0; mem_wrdata=0; accumulator and counters=0.
- Reset mid-operation aborts the command with no response. A stale mem_rdvalid arriving after reset is ignored.
- States: IDLE, WR, RD_ISSUE, ISSUE, DRAIN, FILL, RESP.
- All mem_* outputs are registered. mem_rqvalid and mem_wren are never high together.
- IDLE: cmd_ready=1. On handshake, latch op/addr/data and len_eff = min(cmd_len, DEPTH). Next state:
  - WRITE -> WR.
  - READ -> ISSUE with len_eff=1.
  - SUM -> ISSUE, or RESP with data 0 if len_eff=0.
  - FILL -> FILL, or RESP with data 0 if len_eff=0.
- WR: one cycle of mem_wren=1 at latched addr/data. resp_data=1. Then RESP.
- ISSUE: mem_rqvalid=1 for len_eff consecutive cycles, address incrementing mod DEPTH (1023 wraps to 0). After the last issue, go to DRAIN.
- Return path (ISSUE and DRAIN): each mem_rdvalid adds mem_rddata to a DATA_W accumulator, modulo 2^DATA_W with carry-out discarded. DRAIN -> RESP once received count == len_eff.
  - READ: response is the single word.
  - SUM: response is the accumulated sum.
- FILL: mem_wren=1 for len_eff consecutive cycles, addresses incrementing mod DEPTH, mem_wrdata = latched data. resp_data = len_eff (zero-extended). Then RESP.
- mem_rdvalid in IDLE, WR, FILL or RESP is ignored.
- RESP: resp_valid=1 with resp_data stable. Hold until resp_ready; on the handshake edge go to IDLE. resp_ready has no effect outside RESP.
- cmd_ready is 0 in every state other than IDLE, so there is no overlap between commands.
- Latency, counted from the accept edge to resp_valid high:
  - WRITE: 2 cycles.
  - READ: 3 cycles.
  - SUM of N: N+2 cycles.
  - FILL of N: N+1 cycles.
  - len 0: 1 cycle.
- Writes by this block never overlap its own reads, so the memory's read-before-write behaviour on a same-cycle collision is never exercised.

Decomposition:
- Shared package mymem_pkg: op encoding (OP_WRITE/OP_READ/OP_SUM/OP_FILL), state enum, ADDR_W/DATA_W/LEN_W defaults, DEPTH.
- No sub-module; a single FSM with address/issue/receive counters and the accumulator.

Test Plan:
- WRITE addr 5 data 0xDEAD_BEEF, then READ addr 5 -> READ resp_data 0xDEAD_BEEF; WRITE resp_valid 2 cycles after accept; READ resp_valid 3 cycles after accept.
- FILL addr 1020 len 8 data 7 -> writes to 1020..1023,0..3 (wrap), resp_data 8; then SUM addr 1020 len 8 -> resp_data 56, resp_valid 10 cycles after accept.
- SUM len 2047 with all words 0xFFFF_FFFF_FFFF_FFFF -> clamped to 1024 requests; resp_data 0xFFFF_FFFF_FFFF_FC00 (wrapping sum).
- SUM len 0 and FILL len 0 -> no mem_rqvalid/mem_wren activity, resp_data 0, resp_valid 1 cycle after accept.
- Hold resp_ready=0 for 20 cycles in RESP -> resp_valid and resp_data stable, cmd_ready=0, no memory activity; release -> IDLE next cycle.
- Assert reset_n=0 mid-SUM (len 100, cycle 40), release -> all outputs at reset values, no response, the next READ returns correct data.
